// File: rtl/hello_marquee.sv
`default_nettype none
// ============================================================================
// Module   : hello_marquee
// Brief    : Scrolling "HELLO" marquee on a 4-digit multiplexed, active-low
//            seven-segment display. Eight slide switches select pause,
//            direction, blanking and scroll speed.
// Options  : HELLO_MARQUEE_DEGHOST_EN - when defined, all digit enables are
//            held off during slot-counter values 0 and 1 of every slot to
//            suppress ghosting between neighbouring digits.
// Revision : 1.0 - initial release
// ============================================================================
module hello_marquee #(
  parameter int CLK_DIV = 100  // clocks per digit slot, must be >= 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sw,
  output logic [6:0] ss,
  output logic [4:1] dig
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int                  c_SLOT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [c_SLOT_W-1:0] c_SLOT_LAST = c_SLOT_W'(CLK_DIV - 1);
  localparam logic [c_SLOT_W-1:0] c_SLOT_ONE  = c_SLOT_W'(1);

  // Active-low glyphs, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] c_SEG_H     = 7'h09;
  localparam logic [6:0] c_SEG_E     = 7'h06;
  localparam logic [6:0] c_SEG_L     = 7'h47;
  localparam logic [6:0] c_SEG_O     = 7'h40;
  localparam logic [6:0] c_SEG_BLANK = 7'h7F;
  localparam logic [4:1] c_DIG_OFF   = 4'b1111;

  // --------------------------------------------------------------------------
  // Signals
  // --------------------------------------------------------------------------
  logic [7:0]          r_sw_meta;     // first synchroniser stage
  logic [7:0]          r_sw_s;        // synchronised switches
  logic [c_SLOT_W-1:0] r_slot;        // position within a digit slot
  logic [1:0]          r_scan;        // which digit is being driven
  logic [2:0]          r_ptr;         // message index shown on the leftmost digit
  logic [6:0]          r_frame;       // frames since the last scroll step

  logic [c_SLOT_W-1:0] w_slot_nxt;
  logic [1:0]          w_scan_nxt;
  logic [2:0]          w_ptr_nxt;
  logic [6:0]          w_frame_nxt;
  logic                w_slot_wrap;
  logic                w_frame_end;
  logic                w_step;
  logic [6:0]          w_term;
  logic                w_pause;
  logic                w_reverse;
  logic                w_blank;
  logic [2:0]          w_char_idx;
  logic [6:0]          w_ss_nxt;
  logic [4:1]          w_dig_nxt;
  logic                w_unused_sw3;  // reserved switch, deliberately ignored

  assign w_pause      = r_sw_s[0];
  assign w_reverse    = r_sw_s[1];
  assign w_blank      = r_sw_s[2];
  assign w_unused_sw3 = r_sw_s[3];

  // Terminal frame count is 8*(speed+1)-1, i.e. the speed nibble followed by 3'b111
  assign w_term = {r_sw_s[7:4], 3'b111};

  // Message ROM: H E L L O followed by three blanks
  function automatic logic [6:0] f_glyph(input logic [2:0] idx);
    logic [6:0] seg;
    seg = c_SEG_BLANK;
    case (idx)
      3'd0:    seg = c_SEG_H;
      3'd1:    seg = c_SEG_E;
      3'd2:    seg = c_SEG_L;
      3'd3:    seg = c_SEG_L;
      3'd4:    seg = c_SEG_O;
      default: seg = c_SEG_BLANK;
    endcase
    return seg;
  endfunction

  // --------------------------------------------------------------------------
  // Two-flop switch synchroniser; switches never reach the pins combinationally
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sw_meta <= '0;
      r_sw_s    <= '0;
    end else begin
      r_sw_meta <= sw;
      r_sw_s    <= r_sw_meta;
    end
  end

  // --------------------------------------------------------------------------
  // Slot counter and scan index next-state: slot wraps advance the scan index
  // --------------------------------------------------------------------------
  always_comb begin
    w_slot_wrap = (r_slot == c_SLOT_LAST);
    w_slot_nxt  = w_slot_wrap ? '0 : (r_slot + c_SLOT_ONE);
    w_scan_nxt  = w_slot_wrap ? (r_scan + 2'd1) : r_scan;
    w_frame_end = w_slot_wrap && (r_scan == 2'd3);
  end

  // --------------------------------------------------------------------------
  // Scroll timing: count frames, step the pointer once the terminal count is
  // met or exceeded (so a speed change below the current count steps at the
  // next frame end). Pause freezes both the pointer and the frame counter.
  // --------------------------------------------------------------------------
  always_comb begin
    w_frame_nxt = r_frame;
    w_ptr_nxt   = r_ptr;
    w_step      = 1'b0;
    if (w_frame_end && !w_pause) begin
      if (r_frame >= w_term) begin
        w_step      = 1'b1;
        w_frame_nxt = '0;
      end else begin
        w_frame_nxt = r_frame + 7'd1;
      end
    end
    if (w_step) begin
      w_ptr_nxt = w_reverse ? (r_ptr - 3'd1) : (r_ptr + 3'd1);
    end
  end

  // --------------------------------------------------------------------------
  // Counter and pointer state registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot  <= '0;
      r_scan  <= '0;
      r_ptr   <= '0;
      r_frame <= '0;
    end else begin
      r_slot  <= w_slot_nxt;
      r_scan  <= w_scan_nxt;
      r_ptr   <= w_ptr_nxt;
      r_frame <= w_frame_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Pin values are decoded from next-state counters so the registered pins
  // switch on the same edge as the scan index does.
  // --------------------------------------------------------------------------
  always_comb begin
    // 3-bit add wraps the circular message index naturally
    w_char_idx = w_ptr_nxt + {1'b0, w_scan_nxt};
    w_ss_nxt   = f_glyph(w_char_idx);
    w_dig_nxt  = c_DIG_OFF;
    case (w_scan_nxt)
      2'd0:    w_dig_nxt = 4'b0111;
      2'd1:    w_dig_nxt = 4'b1011;
      2'd2:    w_dig_nxt = 4'b1101;
      default: w_dig_nxt = 4'b1110;
    endcase
`ifdef HELLO_MARQUEE_DEGHOST_EN
    // Dead time at the start of every slot while segments settle
    if (w_slot_nxt <= c_SLOT_ONE) begin
      w_dig_nxt = c_DIG_OFF;
    end
`endif
    // Blanking only masks the pins; counters keep running to stay in phase
    if (w_blank) begin
      w_dig_nxt = c_DIG_OFF;
      w_ss_nxt  = c_SEG_BLANK;
    end
  end

  // --------------------------------------------------------------------------
  // Registered display pins, dark during reset
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss  <= c_SEG_BLANK;
      dig <= c_DIG_OFF;
    end else begin
      ss  <= w_ss_nxt;
      dig <= w_dig_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hello_marquee.sv
`default_nettype none
// ============================================================================
// Module   : tb_hello_marquee
// Brief    : Scoreboard bench for hello_marquee. Stimulus queues expected
//            {dig, ss} values tagged with the clock count at which they must
//            hold; an independent monitor compares them on falling edges.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hello_marquee;

  localparam int c_DIV = 100;

  logic       clk;
  logic       rst_n;
  logic [7:0] sw;
  logic [6:0] ss;
  logic [4:1] dig;

  hello_marquee #(.CLK_DIV(c_DIV)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sw    (sw),
    .ss    (ss),
    .dig   (dig)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running rising-edge count, never reset
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic [4:1] dig;
    logic [6:0] ss;
  } exp_t;

  exp_t  q_exp[$];
  string q_name[$];
  int    checks = 0;
  int    errors = 0;

  // Queue one expectation, n rising edges after reset release at base cycle r
  task automatic expect_at(input int r, input int n, input logic [4:1] d,
                           input logic [6:0] s, input string name);
    exp_t e;
    e.at  = r + n;
    e.dig = d;
    e.ss  = s;
    q_exp.push_back(e);
    q_name.push_back(name);
  endtask

  // Monitor: compare the head entry on the falling edge it is due
  always @(negedge clk) begin
    exp_t  e;
    string nm;
    if (q_exp.size() > 0) begin
      if (q_exp[0].at < cyc) begin
        e  = q_exp.pop_front();
        nm = q_name.pop_front();
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL %s: sample point %0d missed at cycle %0d", nm, e.at, cyc);
      end else if (q_exp[0].at == cyc) begin
        e  = q_exp.pop_front();
        nm = q_name.pop_front();
        checks = checks + 1;
        if (dig !== e.dig || ss !== e.ss) begin
          errors = errors + 1;
          $display("FAIL %s: got dig=%b ss=%h, expected dig=%b ss=%h",
                   nm, dig, ss, e.dig, e.ss);
        end
      end
    end
  end

  // Assert reset just after a rising edge (mid-slot), expect dark pins before
  // the next edge, then release on a falling edge. r returns the release cycle.
  task automatic do_reset(input logic [7:0] s, output int r);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    sw    = s;
    expect_at(cyc, 0, 4'b1111, 7'h7F, "reset_async");
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    r     = cyc;
  endtask

  task automatic wait_to(input int r, input int n);
    while (cyc < r + n) @(negedge clk);
  endtask

  int r;

  initial begin
    rst_n = 1'b0;
    sw    = 8'h00;

    // ---- Forward scroll at fastest speed ----
    do_reset(8'h00, r);
    expect_at(r,   50, 4'b0111, 7'h09, "fwd_d4_H");
    expect_at(r,  150, 4'b1011, 7'h06, "fwd_d3_E");
    expect_at(r,  250, 4'b1101, 7'h47, "fwd_d2_L");
    expect_at(r,  350, 4'b1110, 7'h47, "fwd_d1_L");
    expect_at(r, 3150, 4'b1110, 7'h47, "fwd_prestep_d1");
    expect_at(r, 3250, 4'b0111, 7'h06, "fwd_step_d4_E");
    expect_at(r, 3350, 4'b1011, 7'h47, "fwd_step_d3_L");
    expect_at(r, 3450, 4'b1101, 7'h47, "fwd_step_d2_L");
    expect_at(r, 3550, 4'b1110, 7'h40, "fwd_step_d1_O");
    wait_to(r, 3550);

    // ---- Speed lowered below current frame count: step at next frame end ----
    do_reset(8'h10, r);
    wait_to(r, 4020);
    sw = 8'h00;
    expect_at(r, 4350, 4'b1110, 7'h47, "spdchg_before");
    expect_at(r, 4450, 4'b0111, 7'h06, "spdchg_step_E");
    wait_to(r, 4450);

    // ---- Speed 1: one step per 16 frames, full wrap after 8 steps ----
    do_reset(8'h10, r);
    expect_at(r,  6350, 4'b1110, 7'h47, "spd1_p0_d1_L");
    expect_at(r,  6450, 4'b0111, 7'h06, "spd1_p1_d4_E");
    expect_at(r, 12750, 4'b1110, 7'h40, "spd1_p1_d1_O");
    expect_at(r, 12850, 4'b0111, 7'h47, "spd1_p2_d4_L");
    expect_at(r, 51150, 4'b1110, 7'h47, "spd1_p7_d1_L");
    expect_at(r, 51250, 4'b0111, 7'h09, "spd1_wrap_d4_H");
    expect_at(r, 51350, 4'b1011, 7'h06, "spd1_wrap_d3_E");
    expect_at(r, 51450, 4'b1101, 7'h47, "spd1_wrap_d2_L");
    expect_at(r, 51550, 4'b1110, 7'h47, "spd1_wrap_d1_L");
    wait_to(r, 51550);

    // ---- Reverse: pointer 0 wraps to 7 ----
    do_reset(8'h02, r);
    expect_at(r, 3250, 4'b0111, 7'h7F, "rev_d4_blank");
    expect_at(r, 3350, 4'b1011, 7'h09, "rev_d3_H");
    expect_at(r, 3450, 4'b1101, 7'h06, "rev_d2_E");
    expect_at(r, 3550, 4'b1110, 7'h47, "rev_d1_L");
    wait_to(r, 3550);

    // ---- Pause holds the pointer, then blanking keeps counters in phase ----
    do_reset(8'h01, r);
    expect_at(r,  3250, 4'b0111, 7'h09, "pause_nostep_H");
    expect_at(r,  9650, 4'b0111, 7'h09, "pause_late_d4_H");
    expect_at(r,  9950, 4'b1110, 7'h47, "pause_late_d1_L");
    expect_at(r, 10050, 4'b1111, 7'h7F, "blank_a");
    expect_at(r, 10150, 4'b1111, 7'h7F, "blank_b");
    expect_at(r, 10250, 4'b1101, 7'h47, "unblank_phase_d2");
    wait_to(r, 10020);
    sw = 8'h04;
    wait_to(r, 10160);
    sw = 8'h00;
    wait_to(r, 10250);

    // ---- Reset mid-slot, then scan restarts at the leftmost digit ----
    do_reset(8'h00, r);
`ifdef HELLO_MARQUEE_DEGHOST_EN
    expect_at(r,   1, 4'b1111, 7'h09, "restart_first_edge");
`else
    expect_at(r,   1, 4'b0111, 7'h09, "restart_first_edge");
`endif
    expect_at(r,  50, 4'b0111, 7'h09, "restart_d4_H");
    expect_at(r, 150, 4'b1011, 7'h06, "restart_d3_E");
    wait_to(r, 150);

    // Drain: anything left unchecked is a failure
    for (int i = 0; i < 20 && q_exp.size() > 0; i++) @(negedge clk);
    if (q_exp.size() > 0) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL drain: %0d expectations never sampled, expected 0", q_exp.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
